// File: rtl/cim_accum_mem_if.sv
// Bundle of PE tile channels and the scan port of the CIM accumulation memory.
// The testbench drives through "master"; the memory block attaches as "slave".
interface cim_accum_mem_if #(
    parameter int NUM_CH = 2,
    parameter int TILE   = 6,
    parameter int PIX_W  = 12,
    parameter int ACC_W  = 14,
    parameter int DEPTH  = 256
);
    localparam int E      = TILE * TILE;
    localparam int LINE_W = E * ACC_W;
    localparam int ADDR_W = $clog2(DEPTH);

    logic [NUM_CH*E*PIX_W-1:0]  pe_tile_i;
    logic [NUM_CH*ADDR_W-1:0]   pe_addr_i;
    logic [NUM_CH-1:0]          pe_valid_i;
    logic [NUM_CH-1:0]          pe_ready_o;
    logic [1:0]                 scan_mode_i;
    logic [ADDR_W-1:0]          scan_addr_i;
    logic [LINE_W-1:0]          scan_in_i;
    logic [LINE_W-1:0]          scan_out_o;
    logic                       scan_valid_o;
    logic                       busy_o;
    logic [15:0]                sat_count_o;

    modport master (
        output pe_tile_i, pe_addr_i, pe_valid_i, scan_mode_i, scan_addr_i, scan_in_i,
        input  pe_ready_o, scan_out_o, scan_valid_o, busy_o, sat_count_o
    );
    modport slave (
        input  pe_tile_i, pe_addr_i, pe_valid_i, scan_mode_i, scan_addr_i, scan_in_i,
        output pe_ready_o, scan_out_o, scan_valid_o, busy_o, sat_count_o
    );
endinterface

// File: rtl/cim_accum_mem.sv
// Shared accumulation memory: NUM_CH PE channels read-modify-write saturating tiles
// through a 3-stage pipeline with RAW stalls; a scan port writes, reads and clears lines.
module cim_accum_mem #(
    parameter int NUM_CH = 2,
    parameter int TILE   = 6,
    parameter int PIX_W  = 12,
    parameter int ACC_W  = 14,
    parameter int DEPTH  = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    cim_accum_mem_if.slave bus
);
    localparam int E      = TILE * TILE;
    localparam int LINE_W = E * ACC_W;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(E + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_SWEEP = 2'b10
    } clr_state_e;

    logic [LINE_W-1:0]  mem_q [DEPTH];
    logic [NUM_CH-1:0]  s1_vld_q, s2_vld_q;
    logic [ADDR_W-1:0]  s1_addr_q [NUM_CH];
    logic [ADDR_W-1:0]  s2_addr_q [NUM_CH];
    logic [E*PIX_W-1:0] s1_tile_q [NUM_CH];
    logic [LINE_W-1:0]  s2_data_q [NUM_CH];
    logic [CNT_W-1:0]   s2_cnt_q  [NUM_CH];
    logic [LINE_W-1:0]  sum_s     [NUM_CH];
    logic [CNT_W-1:0]   cnt_s     [NUM_CH];
    logic [NUM_CH-1:0]  ready_s, accept_s;
    clr_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic [1:0]         prev_mode_q;
    logic [LINE_W-1:0]  scan_out_q;
    logic               scan_valid_q, busy_q, busy_d;
    logic [15:0]        sat_cnt_q, sat_cnt_d;
    logic               pipe_empty_s, clr_trig_s, scan_ok_s;

    // Add a PIX_W tile element onto an ACC_W accumulator; MSB of the result flags a clamp.
    function automatic logic [ACC_W:0] sat_add(input logic signed [PIX_W-1:0] pix,
                                               input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] sum;
        sum = (ACC_W+1)'(pix) + (ACC_W+1)'(acc);
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W]) sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            else            sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_add = {1'b0, sum[ACC_W-1:0]};
        end
    endfunction

    assign pipe_empty_s = ~(|s1_vld_q) & ~(|s2_vld_q);
    assign clr_trig_s   = (bus.scan_mode_i == 2'b11) && (prev_mode_q != 2'b11);
    assign scan_ok_s    = rst_n && pipe_empty_s && (state_q == ST_IDLE);
    assign accept_s     = bus.pe_valid_i & ready_s;
    assign busy_d       = (|accept_s) | (|s1_vld_q) | (state_d != ST_IDLE);

    // Per-channel ready: compute mode, lower-index address priority, RAW stall on S1/S2.
    always_comb begin : p_ready
        logic blk;
        blk = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            blk = 1'b0;
            for (int j = 0; j < NUM_CH; j++) begin
                blk = blk
                    | ((j < k) && bus.pe_valid_i[j]
                       && (bus.pe_addr_i[j*ADDR_W +: ADDR_W] == bus.pe_addr_i[k*ADDR_W +: ADDR_W]))
                    | (s1_vld_q[j] && (s1_addr_q[j] == bus.pe_addr_i[k*ADDR_W +: ADDR_W]))
                    | (s2_vld_q[j] && (s2_addr_q[j] == bus.pe_addr_i[k*ADDR_W +: ADDR_W]));
            end
            ready_s[k] = rst_n && (bus.scan_mode_i == 2'b00) && (state_q == ST_IDLE) && !blk;
        end
    end

    // S1 read-modify: saturating element sums against the current line and clamp count.
    always_comb begin : p_sum
        logic [ACC_W:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum_s[k] = '0;
            cnt_s[k] = '0;
            for (int i = 0; i < E; i++) begin
                r = sat_add(s1_tile_q[k][i*PIX_W +: PIX_W], mem_q[s1_addr_q[k]][i*ACC_W +: ACC_W]);
                sum_s[k][i*ACC_W +: ACC_W] = r[ACC_W-1:0];
                cnt_s[k] = cnt_s[k] + CNT_W'(r[ACC_W]);
            end
        end
    end

    // Saturation counter next value; a clear sweep zeroes it.
    always_comb begin : p_sat
        logic [16:0] tot;
        tot = {1'b0, sat_cnt_q};
        for (int k = 0; k < NUM_CH; k++) begin
            tot = tot + (s2_vld_q[k] ? 17'(s2_cnt_q[k]) : 17'd0);
        end
        if (state_q == ST_SWEEP)    sat_cnt_d = 16'd0;
        else if (tot > 17'h0FFFF)   sat_cnt_d = 16'hFFFF;
        else                        sat_cnt_d = tot[15:0];
    end

    // Clear sequencer next state: wait for drain, then one line per cycle.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_trig_s) state_d = ST_DRAIN;
                else            state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (pipe_empty_s) begin
                    state_d    = ST_SWEEP;
                    clr_addr_d = '0;
                end else begin
                    state_d    = ST_DRAIN;
                end
            end
            ST_SWEEP: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
                else                                  state_d = ST_SWEEP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pipeline stage registers; reset discards in-flight tiles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= '0;
            s2_vld_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                s1_addr_q[k] <= '0;
                s1_tile_q[k] <= '0;
                s2_addr_q[k] <= '0;
                s2_data_q[k] <= '0;
                s2_cnt_q[k]  <= '0;
            end
        end else begin
            s1_vld_q <= accept_s;
            s2_vld_q <= s1_vld_q;
            for (int k = 0; k < NUM_CH; k++) begin
                if (accept_s[k]) begin
                    s1_addr_q[k] <= bus.pe_addr_i[k*ADDR_W +: ADDR_W];
                    s1_tile_q[k] <= bus.pe_tile_i[k*E*PIX_W +: E*PIX_W];
                end
                s2_addr_q[k] <= s1_addr_q[k];
                s2_data_q[k] <= sum_s[k];
                s2_cnt_q[k]  <= cnt_s[k];
            end
        end
    end

    // Memory array: S2 write-back, scan write and clear sweep; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (s2_vld_q[k]) mem_q[s2_addr_q[k]] <= s2_data_q[k];
            end
            if (scan_ok_s && (bus.scan_mode_i == 2'b01)) mem_q[bus.scan_addr_i] <= bus.scan_in_i;
            if (state_q == ST_SWEEP) mem_q[clr_addr_q] <= '0;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            clr_addr_q   <= '0;
            prev_mode_q  <= 2'b00;
            scan_out_q   <= '0;
            scan_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            sat_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            prev_mode_q  <= bus.scan_mode_i;
            busy_q       <= busy_d;
            sat_cnt_q    <= sat_cnt_d;
            scan_valid_q <= scan_ok_s && (bus.scan_mode_i == 2'b10);
            if (scan_ok_s && (bus.scan_mode_i == 2'b10)) scan_out_q <= mem_q[bus.scan_addr_i];
        end
    end

    assign bus.pe_ready_o   = ready_s;
    assign bus.scan_out_o   = scan_out_q;
    assign bus.scan_valid_o = scan_valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.sat_count_o  = sat_cnt_q;
endmodule

// File: tb/tb_cim_accum_mem.sv
// Directed plus randomized bench for cim_accum_mem against an array-level
// memory model with element saturation and a time-based hazard rule.
module tb_cim_accum_mem;
    localparam int NUM_CH  = 2;
    localparam int TILE    = 6;
    localparam int PIX_W   = 12;
    localparam int ACC_W   = 14;
    localparam int DEPTH   = 256;
    localparam int E       = TILE * TILE;
    localparam int LINE_W  = E * ACC_W;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cim_accum_mem_if #(.NUM_CH(NUM_CH), .TILE(TILE), .PIX_W(PIX_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) bus ();
    cim_accum_mem #(.NUM_CH(NUM_CH), .TILE(TILE), .PIX_W(PIX_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mem_m [DEPTH][E];
    int sat_m = 0;
    int tile_m [NUM_CH][E];
    int addr_m [NUM_CH];
    int acc_cyc [NUM_CH];
    int last_acc [DEPTH];
    int first_acc, busy_cnt, n;
    logic [1:0] hold, v, exp_rdy;
    logic [LINE_W-1:0] old_line;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [LINE_W-1:0] mline(input int a);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < E; i++) l[i*ACC_W +: ACC_W] = ACC_W'(mem_m[a][i]);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] const_line(input int val);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < E; i++) l[i*ACC_W +: ACC_W] = ACC_W'(val);
        return l;
    endfunction

    function automatic void model_acc(input int k);
        int a;
        int s;
        a = addr_m[k];
        for (int i = 0; i < E; i++) begin
            s = mem_m[a][i] + tile_m[k][i];
            if (s > ACC_MAX) begin
                s = ACC_MAX;
                if (sat_m < 65535) sat_m++;
            end else if (s < ACC_MIN) begin
                s = ACC_MIN;
                if (sat_m < 65535) sat_m++;
            end
            mem_m[a][i] = s;
        end
    endfunction

    function automatic void model_clear();
        for (int a = 0; a < DEPTH; a++)
            for (int i = 0; i < E; i++) mem_m[a][i] = 0;
        sat_m = 0;
    endfunction

    task automatic drive_ch(input int k);
        bus.pe_addr_i[k*ADDR_W +: ADDR_W] = ADDR_W'(addr_m[k]);
        for (int i = 0; i < E; i++) bus.pe_tile_i[(k*E+i)*PIX_W +: PIX_W] = PIX_W'(tile_m[k][i]);
    endtask

    task automatic set_const(input int k, input int a, input int val);
        addr_m[k] = a;
        for (int i = 0; i < E; i++) tile_m[k][i] = val;
        drive_ch(k);
    endtask

    // Hold valid on the enabled channels until each is accepted once.
    task automatic send(input logic [1:0] en);
        logic [1:0] pend;
        int cnt;
        pend = en;
        cnt = 0;
        bus.pe_valid_i = pend;
        while (pend != 2'b00 && cnt < 20) begin
            @(negedge clk);
            for (int k = 0; k < NUM_CH; k++) begin
                if (pend[k] && bus.pe_ready_o[k]) begin
                    acc_cyc[k] = cyc;
                    model_acc(k);
                    pend[k] = 1'b0;
                end
            end
            tick();
            cnt++;
            bus.pe_valid_i = pend;
        end
        chk("send_accepted", 64'(pend), 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        int cnt;
        cnt = 0;
        while (bus.busy_o !== 1'b0 && cnt < 600) begin
            tick();
            cnt++;
        end
        chk(tag, 64'(bus.busy_o), 64'd0);
    endtask

    task automatic scan_write(input int a, input logic [LINE_W-1:0] line);
        bus.scan_mode_i = 2'b01;
        bus.scan_addr_i = ADDR_W'(a);
        bus.scan_in_i   = line;
        tick();
        bus.scan_mode_i = 2'b00;
        for (int i = 0; i < E; i++) mem_m[a][i] = int'($signed(line[i*ACC_W +: ACC_W]));
    endtask

    task automatic scan_check(input int a);
        bus.scan_mode_i = 2'b10;
        bus.scan_addr_i = ADDR_W'(a);
        tick();
        chk($sformatf("scan_valid_%0d", a), 64'(bus.scan_valid_o), 64'd1);
        chk_line($sformatf("line_%0d", a), bus.scan_out_o, mline(a));
        bus.scan_mode_i = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pe_tile_i   = '0;
        bus.pe_addr_i   = '0;
        bus.pe_valid_i  = '0;
        bus.scan_mode_i = 2'b11;
        bus.scan_addr_i = '0;
        bus.scan_in_i   = '0;

        // Reset with clear mode held: outputs quiet, then a clear runs on exit.
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_scan_valid", 64'(bus.scan_valid_o), 64'd0);
        chk("rst_sat", 64'(bus.sat_count_o), 64'd0);
        chk("rst_scan_out_lsw", bus.scan_out_o[63:0], 64'd0);
        chk("rst_ready", 64'(bus.pe_ready_o), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("clear_after_reset_busy", 64'(bus.busy_o), 64'd1);
        wait_idle("init_clear_done");
        model_clear();
        tick();
        tick();
        tick();
        chk("clear_held_no_retrigger", 64'(bus.busy_o), 64'd0);
        bus.scan_mode_i = 2'b00;
        tick();

        // Back-to-back accumulate on one address.
        set_const(0, 3, 5);
        send(2'b01);
        first_acc = acc_cyc[0];
        send(2'b01);
        chk("b2b_spacing", 64'(acc_cyc[0] - first_acc), 64'd3);
        wait_idle("b2b_idle");
        scan_check(3);
        chk("b2b_elem0", 64'(bus.scan_out_o[ACC_W-1:0]), 64'(14'd10));
        tick();
        chk("scan_valid_drop", 64'(bus.scan_valid_o), 64'd0);

        // Same-cycle conflict: channel 0 wins, channel 1 follows three cycles later.
        set_const(0, 7, 1);
        set_const(1, 7, 2);
        send(2'b11);
        chk("conflict_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
        wait_idle("conflict_idle");
        scan_check(7);
        chk("conflict_elem35", 64'(bus.scan_out_o[35*ACC_W +: ACC_W]), 64'(14'd3));

        // Parallel streams to disjoint address ranges.
        for (int i = 0; i < 10; i++) begin
            addr_m[0] = i;
            addr_m[1] = 100 + i;
            for (int k = 0; k < NUM_CH; k++) begin
                for (int e = 0; e < E; e++) tile_m[k][e] = int'($urandom_range(0, 200)) - 100;
                drive_ch(k);
            end
            bus.pe_valid_i = 2'b11;
            @(negedge clk);
            chk($sformatf("par_ready_%0d", i), 64'(bus.pe_ready_o), 64'd3);
            for (int k = 0; k < NUM_CH; k++) if (bus.pe_ready_o[k]) model_acc(k);
            tick();
        end
        bus.pe_valid_i = 2'b00;
        chk("par_busy_s1", 64'(bus.busy_o), 64'd1);
        tick();
        chk("par_busy_s2", 64'(bus.busy_o), 64'd1);
        tick();
        chk("par_busy_drop", 64'(bus.busy_o), 64'd0);
        for (int i = 0; i < 10; i++) begin
            scan_check(i);
            scan_check(100 + i);
        end

        // Saturation at both rails.
        scan_write(0, const_line(8190));
        set_const(0, 0, 10);
        send(2'b01);
        wait_idle("satp_idle");
        scan_check(0);
        chk("satp_count", 64'(bus.sat_count_o), 64'(sat_m));
        scan_write(0, const_line(-8190));
        set_const(0, 0, -10);
        send(2'b01);
        wait_idle("satn_idle");
        scan_check(0);
        chk("satn_elem0", 64'(bus.scan_out_o[ACC_W-1:0]), 64'(14'h2000));
        chk("satn_count", 64'(bus.sat_count_o), 64'd72);

        // Randomized traffic on a few shared addresses with held valids.
        for (int a = 0; a < DEPTH; a++) last_acc[a] = -10;
        hold = 2'b00;
        v = 2'b00;
        for (int it = 0; it < 150; it++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!hold[k]) begin
                    v[k] = ($urandom_range(0, 3) != 0);
                    addr_m[k] = int'($urandom_range(0, 5));
                    for (int e = 0; e < E; e++) tile_m[k][e] = int'($urandom_range(0, 4095)) - 2048;
                    drive_ch(k);
                end
            end
            bus.pe_valid_i = v;
            @(negedge clk);
            for (int k = 0; k < NUM_CH; k++) begin
                exp_rdy[k] = 1'b1;
                for (int j = 0; j < k; j++)
                    if (v[j] && addr_m[j] == addr_m[k]) exp_rdy[k] = 1'b0;
                if (it - last_acc[addr_m[k]] < 3) exp_rdy[k] = 1'b0;
            end
            chk($sformatf("rand_ready_%0d", it), 64'(bus.pe_ready_o), 64'(exp_rdy));
            for (int k = 0; k < NUM_CH; k++) begin
                if (v[k] && bus.pe_ready_o[k]) begin
                    model_acc(k);
                    last_acc[addr_m[k]] = it;
                    hold[k] = 1'b0;
                end else begin
                    hold[k] = v[k];
                end
            end
            tick();
        end
        bus.pe_valid_i = 2'b00;
        wait_idle("rand_idle");
        for (int a = 0; a < 6; a++) scan_check(a);
        chk("rand_sat_count", 64'(bus.sat_count_o), 64'(sat_m));

        // Clear requested mid-stream, mode dropped back after five cycles.
        set_const(0, 20, 9);
        set_const(1, 30, -9);
        bus.pe_valid_i = 2'b11;
        @(negedge clk);
        for (int k = 0; k < NUM_CH; k++) if (bus.pe_ready_o[k]) model_acc(k);
        tick();
        bus.pe_valid_i = 2'b00;
        bus.scan_mode_i = 2'b11;
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.busy_o === 1'b1) busy_cnt++;
        end
        bus.scan_mode_i = 2'b00;
        #1;
        chk("clear_ready_blocked", 64'(bus.pe_ready_o), 64'd0);
        n = 0;
        while (bus.busy_o === 1'b1 && n < 400) begin
            tick();
            n++;
            if (bus.busy_o === 1'b1) busy_cnt++;
        end
        chk("clear_busy_span", 64'((busy_cnt >= 256) && (busy_cnt <= 260)), 64'd1);
        chk("clear_ended", 64'(bus.busy_o), 64'd0);
        model_clear();
        chk("clear_sat", 64'(bus.sat_count_o), 64'd0);
        foreach (last_acc[a]) if (a < 10 || a == 20 || a == 30 || a == 100 || a == 255) scan_check(a);

        // Reset while S2 holds a write to line 5.
        scan_write(5, const_line(77));
        scan_check(5);
        set_const(0, 5, 1);
        bus.pe_valid_i = 2'b01;
        @(negedge clk);
        chk("rst_accept", 64'(bus.pe_ready_o[0]), 64'd1);
        tick();
        bus.pe_valid_i = 2'b00;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_ready_low", 64'(bus.pe_ready_o), 64'd0);
        tick();
        chk("rst_mid_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_mid_scan_valid", 64'(bus.scan_valid_o), 64'd0);
        chk("rst_mid_sat", 64'(bus.sat_count_o), 64'd0);
        chk_line("rst_mid_scan_out", bus.scan_out_o, '0);
        sat_m = 0;
        rst_n = 1'b1;
        tick();
        tick();
        old_line = const_line(77);
        scan_check(5);
        chk_line("rst_line5_kept", bus.scan_out_o, old_line);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cim_accum_mem.md
Name: cim_accum_mem

Overview:
- Parametrised successor to the dual-channel CIM output-memory top.
- NUM_CH independent PE channels push 6x6 Winograd output tiles, with a line address, into a shared accumulation memory.
- Each accepted tile is read-modify-write accumulated with per-element saturation in a 3-stage pipeline, with valid/ready backpressure and same-address hazard stalls.
- An off-chip scan port supports line write, line read and a whole-memory clear sweep.

Parameters:
- NUM_CH, 2, number of PE channels.
- TILE, 6, tile edge; elements per line E = TILE*TILE.
- PIX_W, 12, signed PE element width.
- ACC_W, 14, signed accumulator element width; LINE_W = E*ACC_W.
- DEPTH, 256, memory lines; ADDR_W = $clog2(DEPTH).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- pe_tile_i  in  NUM_CH*E*PIX_W  channel k occupies [k*E*PIX_W +: E*PIX_W]; element (r,c) is at index r*TILE+c within the channel slice.
- pe_addr_i  in  NUM_CH*ADDR_W  per-channel line address.
- pe_valid_i  in  NUM_CH  per-channel tile valid.
- pe_ready_o  out  NUM_CH  per-channel accept; transfer happens when valid&ready at the clock edge.
- scan_mode_i  in  2  00 compute, 01 scan write, 10 scan read, 11 clear.
- scan_addr_i  in  ADDR_W  scan line address.
- scan_in_i  in  LINE_W  scan write data; element i is at [i*ACC_W +: ACC_W].
- scan_out_o  out  LINE_W  registered scan read data.
- scan_valid_o  out  1  scan_out_o holds valid data this cycle.
- busy_o  out  1  pipeline non-empty or clear sweep active.
- sat_count_o  out  16  saturating count of saturated element writes.

Behaviour:
- Reset (rst_n=0 at an edge):
  - Pipeline valids cleared; in-flight writes are dropped.
  - Clear sweep aborted.
  - scan_out_o=0, scan_valid_o=0, busy_o=0, sat_count_o=0.
  - pe_ready_o=0 while rst_n=0.
  - Memory contents are not reset.
- Pipeline per channel, accept at edge E0:
  - S1 holds tile/addr after E0.
  - During S1, mem[addr] is read combinationally. Each element is sign-extended and summed: tile element extended to ACC_W+1 bits plus mem element, then saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - The result is registered into S2 at E1 and written to mem at E2. The write is visible to reads after E2.
  - Throughput: 1 tile/cycle/channel.
- pe_ready_o[k]=1 only when all of the following hold:
  - scan_mode_i==00 and no clear sweep is active;
  - no channel j<k has pe_valid_i[j]=1 with pe_addr_i[j]==pe_addr_i[k] (fixed priority, lowest index wins);
  - pe_addr_i[k] matches no valid S1 or S2 address of any channel (RAW stall).
  - Consequence: same-address accepts are spaced at least 3 cycles apart.
- Ready does not depend on pe_valid_i[k] itself. A held valid must stay stable until accepted.
- Non-compute modes: new accepts stop immediately, and in-flight tiles drain normally. A scan op executes only when both S1 and S2 are empty for all channels.
- Scan write (01): mem[scan_addr_i] <= scan_in_i on every eligible cycle.
- Scan read (10): on an eligible cycle, scan_out_o <= mem[scan_addr_i] and scan_valid_o=1 on the next cycle. Otherwise scan_valid_o=0 and scan_out_o holds its last value.
- Clear (11):
  - Triggered on entry to 11 from another mode, or on 11 held when leaving reset.
  - After drain, sweeps lines 0..DEPTH-1, zeroing one line per cycle, and zeroes sat_count_o. busy_o=1 throughout.
  - The sweep always completes even if scan_mode_i changes mid-sweep.
  - After completion, holding 11 does nothing; mode must leave 11 and return to trigger another clear.
- sat_count_o increments by the number of clamped elements in each S2 write, summed over channels in the same cycle, and saturates at 0xFFFF.
- Different addresses from different channels write in the same cycle without interaction. The stall rules guarantee that two writes to the same line never occur in one cycle.

Test Plan:
- Back-to-back accumulate: clear; ch0 sends all +5 to addr 3 twice with valid held.
  -> Second accept happens exactly 3 cycles after the first; pe_ready_o[0]=0 for 2 cycles; scan read addr 3 returns all 36 elements = 10.
- Same-cycle conflict: ch0 sends +1 and ch1 sends +2, both to addr 7, in the same cycle.
  -> ch0 accepted, ch1 stalled, ch1 accepted 3 cycles later; addr 7 reads all 3.
- Saturation: scan write addr 0 all 8190, then accumulate +10 -> all 8191 and sat_count_o=36.
  - Then scan write all -8190 and accumulate -10 -> all -8192 and sat_count_o=72.
- Parallel streams: ch0 to addrs 0..9 and ch1 to addrs 100..109 for 10 consecutive cycles.
  -> pe_ready_o=11 every cycle; all 20 lines hold their tile values; busy_o drops 2 cycles after the last accept.
- Clear: fill lines with nonzero data, set mode 11 mid-stream, then revert to 00 after 5 cycles.
  -> Pipeline drains; busy_o stays high for 256 sweep cycles; all lines read 0; sat_count_o=0.
- Reset mid-operation: assert rst_n=0 while S2 holds a write to addr 5.
  -> addr 5 keeps its old value; all outputs are 0 the next cycle; pe_ready_o=0 during reset.
